// File: rtl/spl_rd_credit_buffer_pkg.sv
// Shared widths and helpers for the SPL read credit buffer and its response FIFO.
package spl_rd_credit_buffer_pkg;

    localparam int SPL_REQ_W      = 80;
    localparam int SPL_RESP_W     = 528;
    localparam int SPL_RESP_DEPTH = 16;

    // A counter that must hold the value DEPTH itself needs clog2(DEPTH+1) bits.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/spl_rd_credit_buffer_resp_fifo.sv
// Response FIFO: W x DEPTH storage with occupancy count; DEPTH need not be a power of two.
module spl_resp_fifo
    import spl_rd_credit_buffer_pkg::*;
#(
    parameter int W     = SPL_RESP_W,
    parameter int DEPTH = SPL_RESP_DEPTH,
    parameter int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic          valid_o,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; occupancy is tracked by count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/spl_rd_credit_buffer.sv
// Credit-gated SPL read path: a request is issued only when a response slot is already
// reserved, so SPL responses are always accepted regardless of accelerator back-pressure.
module spl_rd_credit_buffer
    import spl_rd_credit_buffer_pkg::*;
#(
    parameter int REQ_W      = SPL_REQ_W,
    parameter int RESP_W     = SPL_RESP_W,
    parameter int RESP_DEPTH = SPL_RESP_DEPTH,
    parameter int CW         = cnt_w(RESP_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_rd_req_valid,
    output logic              acc_rd_req_ready,
    input  logic [REQ_W-1:0]  acc_rd_req_data,
    output logic              spl_rd_req_valid,
    input  logic              spl_rd_req_ready,
    output logic [REQ_W-1:0]  spl_rd_req_data,
    input  logic              spl_rd_resp_valid,
    output logic              spl_rd_resp_ready,
    input  logic [RESP_W-1:0] spl_rd_resp_data,
    output logic              acc_rd_resp_valid,
    input  logic              acc_rd_resp_ready,
    output logic [RESP_W-1:0] acc_rd_resp_data,
    output logic [CW-1:0]     rd_outstanding,
    output logic              idle,
    output logic              err
);

    logic [CW-1:0] out_q, out_d;
    logic          err_q, err_d;
    logic          rdy_q;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   used;
    logic          credit;
    logic          req_fire;
    logic          resp_acc;
    logic          resp_pop;

    // Credit uses registered state only, so a pop frees a slot one cycle later.
    assign used     = {1'b0, out_q} + {1'b0, fifo_count};
    assign credit   = (used < (CW+1)'(RESP_DEPTH));

    assign spl_rd_req_valid = acc_rd_req_valid & credit;
    assign acc_rd_req_ready = spl_rd_req_ready & credit;
    assign spl_rd_req_data  = acc_rd_req_data;

    assign req_fire = spl_rd_req_valid & spl_rd_req_ready;
    // An unsolicited response is dropped so neither the counter nor the FIFO is corrupted.
    assign resp_acc = spl_rd_resp_valid & rdy_q & (out_q != '0);
    assign resp_pop = acc_rd_resp_valid & acc_rd_resp_ready;

    always_comb begin
        out_d = out_q;
        case ({req_fire, resp_acc})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
        err_d = err_q | (spl_rd_resp_valid & (out_q == '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            err_q <= 1'b0;
            rdy_q <= 1'b0;
        end else begin
            out_q <= out_d;
            err_q <= err_d;
            rdy_q <= 1'b1;
        end
    end

    spl_resp_fifo #(
        .W     (RESP_W),
        .DEPTH (RESP_DEPTH),
        .CW    (CW)
    ) u_resp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (resp_acc),
        .data_i  (spl_rd_resp_data),
        .pop_i   (resp_pop),
        .valid_o (acc_rd_resp_valid),
        .data_o  (acc_rd_resp_data),
        .count_o (fifo_count)
    );

    assign spl_rd_resp_ready = rdy_q;
    assign rd_outstanding    = out_q;
    assign idle              = (out_q == '0) && (fifo_count == '0);
    assign err               = err_q;

endmodule

// File: tb/tb_spl_rd_credit_buffer.sv
// Directed bench for spl_rd_credit_buffer with hand-computed expectations.
module tb_spl_rd_credit_buffer;
    import spl_rd_credit_buffer_pkg::*;

    localparam int REQ_W      = SPL_REQ_W;
    localparam int RESP_W     = SPL_RESP_W;
    localparam int RESP_DEPTH = 16;
    localparam int CW         = cnt_w(RESP_DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_rd_req_valid;
    logic              acc_rd_req_ready;
    logic [REQ_W-1:0]  acc_rd_req_data;
    logic              spl_rd_req_valid;
    logic              spl_rd_req_ready;
    logic [REQ_W-1:0]  spl_rd_req_data;
    logic              spl_rd_resp_valid;
    logic              spl_rd_resp_ready;
    logic [RESP_W-1:0] spl_rd_resp_data;
    logic              acc_rd_resp_valid;
    logic              acc_rd_resp_ready;
    logic [RESP_W-1:0] acc_rd_resp_data;
    logic [CW-1:0]     rd_outstanding;
    logic              idle;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    spl_rd_credit_buffer #(
        .REQ_W      (REQ_W),
        .RESP_W     (RESP_W),
        .RESP_DEPTH (RESP_DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .acc_rd_req_valid  (acc_rd_req_valid),
        .acc_rd_req_ready  (acc_rd_req_ready),
        .acc_rd_req_data   (acc_rd_req_data),
        .spl_rd_req_valid  (spl_rd_req_valid),
        .spl_rd_req_ready  (spl_rd_req_ready),
        .spl_rd_req_data   (spl_rd_req_data),
        .spl_rd_resp_valid (spl_rd_resp_valid),
        .spl_rd_resp_ready (spl_rd_resp_ready),
        .spl_rd_resp_data  (spl_rd_resp_data),
        .acc_rd_resp_valid (acc_rd_resp_valid),
        .acc_rd_resp_ready (acc_rd_resp_ready),
        .acc_rd_resp_data  (acc_rd_resp_data),
        .rd_outstanding    (rd_outstanding),
        .idle              (idle),
        .err               (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_reqs(input int n);
        acc_rd_req_valid = 1'b1;
        repeat (n) tick();
        acc_rd_req_valid = 1'b0;
    endtask

    task automatic respond(input int n, input int base);
        spl_rd_resp_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            spl_rd_resp_data = RESP_W'(base + i);
            tick();
        end
        spl_rd_resp_valid = 1'b0;
    endtask

    initial begin
        int fires;
        int prev_fire;
        int nxt;

        rst               = 1'b1;
        acc_rd_req_valid  = 1'b0;
        acc_rd_req_data   = '0;
        spl_rd_req_ready  = 1'b1;
        spl_rd_resp_valid = 1'b0;
        spl_rd_resp_data  = '0;
        acc_rd_resp_ready = 1'b0;

        // 1: reset and idle
        tick();
        tick();
        check("rst_resp_ready", 32'(spl_rd_resp_ready), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_acc_valid", 32'(acc_rd_resp_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_resp_ready", 32'(spl_rd_resp_ready), 32'd1);
        check("post_rst_idle", 32'(idle), 32'd1);
        check("post_rst_outstanding", 32'(rd_outstanding), 32'd0);
        check("post_rst_err", 32'(err), 32'd0);

        // 2: single read
        acc_rd_req_valid = 1'b1;
        acc_rd_req_data  = REQ_W'(32'h1234);
        #1;
        check("single_spl_valid", 32'(spl_rd_req_valid), 32'd1);
        check("single_spl_data", spl_rd_req_data[31:0], 32'h1234);
        check("single_acc_ready", 32'(acc_rd_req_ready), 32'd1);
        tick();
        acc_rd_req_valid = 1'b0;
        check("single_outstanding", 32'(rd_outstanding), 32'd1);
        spl_rd_resp_valid = 1'b1;
        spl_rd_resp_data  = RESP_W'(32'hAB);
        #1;
        check("single_no_bypass", 32'(acc_rd_resp_valid), 32'd0);
        tick();
        spl_rd_resp_valid = 1'b0;
        check("single_resp_valid", 32'(acc_rd_resp_valid), 32'd1);
        check("single_resp_data", acc_rd_resp_data[31:0], 32'hAB);
        check("single_outstanding0", 32'(rd_outstanding), 32'd0);
        check("single_not_idle", 32'(idle), 32'd0);
        acc_rd_resp_ready = 1'b1;
        tick();
        acc_rd_resp_ready = 1'b0;
        check("single_idle", 32'(idle), 32'd1);

        // 3: accelerator stalls, SPL answers every fire on the following cycle
        fires     = 0;
        prev_fire = 0;
        acc_rd_req_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            spl_rd_resp_valid = (prev_fire != 0);
            spl_rd_resp_data  = RESP_W'(32'h100 + fires - 1);
            #1;
            prev_fire = int'(spl_rd_req_valid & spl_rd_req_ready);
            fires += prev_fire;
            tick();
        end
        spl_rd_resp_valid = 1'b0;
        check("stall_fires", 32'(fires), 32'd16);
        check("stall_req_ready", 32'(acc_rd_req_ready), 32'd0);
        check("stall_spl_valid", 32'(spl_rd_req_valid), 32'd0);
        check("stall_outstanding", 32'(rd_outstanding), 32'd0);
        check("stall_head", acc_rd_resp_data[31:0], 32'h100);
        acc_rd_resp_ready = 1'b1;
        #1;
        check("stall_no_comb_credit", 32'(acc_rd_req_ready), 32'd0);
        tick();
        acc_rd_resp_ready = 1'b0;
        check("stall_credit_back", 32'(acc_rd_req_ready), 32'd1);
        check("stall_head_next", acc_rd_resp_data[31:0], 32'h101);
        tick();
        check("stall_one_fired", 32'(rd_outstanding), 32'd1);
        check("stall_credit_gone", 32'(acc_rd_req_ready), 32'd0);
        acc_rd_req_valid = 1'b0;
        respond(1, 32'h110);
        acc_rd_resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("stall_drain_order", acc_rd_resp_data[31:0], 32'(32'h101 + i));
            tick();
        end
        acc_rd_resp_ready = 1'b0;
        check("stall_drained_idle", 32'(idle), 32'd1);

        // 4: fire, accept and pop in the same cycle with outstanding=3, count=2
        fire_reqs(5);
        respond(2, 32'hA0);
        check("sim_pre_outstanding", 32'(rd_outstanding), 32'd3);
        check("sim_pre_head", acc_rd_resp_data[31:0], 32'hA0);
        acc_rd_req_valid  = 1'b1;
        spl_rd_resp_valid = 1'b1;
        spl_rd_resp_data  = RESP_W'(32'hA2);
        acc_rd_resp_ready = 1'b1;
        tick();
        acc_rd_req_valid  = 1'b0;
        spl_rd_resp_valid = 1'b0;
        acc_rd_resp_ready = 1'b0;
        check("sim_outstanding", 32'(rd_outstanding), 32'd3);
        check("sim_head_advanced", acc_rd_resp_data[31:0], 32'hA1);
        respond(3, 32'hA3);
        acc_rd_resp_ready = 1'b1;
        nxt = 32'hA1;
        for (int i = 0; i < 5; i++) begin
            check("sim_drain_order", acc_rd_resp_data[31:0], 32'(nxt + i));
            tick();
        end
        acc_rd_resp_ready = 1'b0;
        check("sim_idle", 32'(idle), 32'd1);

        // 5: unsolicited response
        spl_rd_resp_valid = 1'b1;
        spl_rd_resp_data  = RESP_W'(32'hDEAD);
        tick();
        spl_rd_resp_valid = 1'b0;
        check("err_set", 32'(err), 32'd1);
        check("err_no_push", 32'(acc_rd_resp_valid), 32'd0);
        check("err_no_underflow", 32'(rd_outstanding), 32'd0);
        tick();
        check("err_sticky", 32'(err), 32'd1);
        check("err_idle", 32'(idle), 32'd1);

        // 6: reset with 5 outstanding and 4 buffered
        fire_reqs(9);
        respond(4, 32'hC0);
        check("mid_pre_outstanding", 32'(rd_outstanding), 32'd5);
        check("mid_pre_valid", 32'(acc_rd_resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_outstanding", 32'(rd_outstanding), 32'd0);
        check("mid_rst_valid", 32'(acc_rd_resp_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_resp_ready", 32'(spl_rd_resp_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("mid_post_resp_ready", 32'(spl_rd_resp_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
